// File: rtl/cpu_run_sequencer.sv
// Run controller for single_cycle_cpu: CPU reset pulse, halt/timeout detection, output trace FIFO.
// Optional rolling output signature is enabled by defining CPU_SEQ_SIGNATURE_EN.
module cpu_run_sequencer #(
  parameter int DATA_W        = 32,
  parameter int TRACE_DEPTH   = 16,
  parameter int RESET_CYCLES  = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int MAX_CYCLES    = 1024,
  parameter int CNT_W         = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_W-1:0]              cpu_output,
  output logic                           cpu_reset,
  output logic                           running,
  output logic                           done,
  output logic                           timeout,
  output logic                           overflow,
  output logic [CNT_W-1:0]               cycle_count,
  input  logic                           trace_rd_en,
  output logic [DATA_W-1:0]              trace_rd_data,
  output logic                           trace_empty,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic [DATA_W-1:0]              signature
);

  localparam int AW   = $clog2(TRACE_DEPTH);
  localparam int ST_W = $clog2(STABLE_CYCLES + 1);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(TRACE_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RST  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state, state_nx;
  logic [RC_W-1:0]   rst_cnt;
  logic [ST_W-1:0]   stable_cnt, stable_nx;
  logic              first_run;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] mem [TRACE_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt_inc;
  logic [AW:0]       count_nx;
  logic              changed, halt_hit, max_hit, full, pop, push_req, push_ok;

  // Change detection, halt/timeout conditions and FIFO bookkeeping for this cycle
  always_comb begin
    changed = first_run || (cpu_output != prev);
    if (changed) begin
      stable_nx = ST_W'(1);
    end else if (stable_cnt == ST_W'(STABLE_CYCLES)) begin
      stable_nx = stable_cnt;
    end else begin
      stable_nx = stable_cnt + ST_W'(1);
    end
    cnt_inc  = cycle_count + CNT_W'(1);
    halt_hit = (stable_nx == ST_W'(STABLE_CYCLES));
    max_hit  = (cnt_inc == CNT_W'(MAX_CYCLES));
    full     = (trace_count == DEPTH_C);
    pop      = trace_rd_en && !trace_empty;
    push_req = (state == S_RUN) && changed;
    // a pop in the same cycle frees the slot a full FIFO needs
    push_ok  = push_req && (!full || pop);
    count_nx = trace_count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_RST; else state_nx = S_IDLE;
      S_RST:  if (rst_cnt == RC_W'(RESET_CYCLES - 1)) state_nx = S_RUN; else state_nx = S_RST;
      S_RUN:  if (halt_hit || max_hit) state_nx = S_DONE; else state_nx = S_RUN;
      S_DONE: if (start) state_nx = S_RST; else state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Sequencer state, status outputs and run counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cpu_reset   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      rst_cnt     <= {RC_W{1'b0}};
      cycle_count <= {CNT_W{1'b0}};
      stable_cnt  <= {ST_W{1'b0}};
      first_run   <= 1'b0;
      prev        <= {DATA_W{1'b0}};
    end else begin
      state     <= state_nx;
      cpu_reset <= (state_nx != S_RUN);
      running   <= (state_nx == S_RUN);
      done      <= (state_nx == S_DONE);
      case (state)
        S_RST: begin
          rst_cnt     <= rst_cnt + RC_W'(1);
          cycle_count <= {CNT_W{1'b0}};
          stable_cnt  <= {ST_W{1'b0}};
          first_run   <= 1'b1;
          timeout     <= 1'b0;
        end
        S_RUN: begin
          cycle_count <= cnt_inc;
          stable_cnt  <= stable_nx;
          first_run   <= 1'b0;
          prev        <= cpu_output;
          // halt has priority when both limits land on the same cycle
          timeout     <= max_hit && !halt_hit;
        end
        default: begin
          rst_cnt <= {RC_W{1'b0}};
        end
      endcase
    end
  end

  // Trace FIFO pointers, occupancy, overflow flag and read data
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr        <= {AW{1'b0}};
      rd_ptr        <= {AW{1'b0}};
      trace_count   <= {(AW + 1){1'b0}};
      trace_empty   <= 1'b1;
      overflow      <= 1'b0;
      trace_rd_data <= {DATA_W{1'b0}};
    end else if (state == S_RST) begin
      wr_ptr      <= {AW{1'b0}};
      rd_ptr      <= {AW{1'b0}};
      trace_count <= {(AW + 1){1'b0}};
      trace_empty <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr        <= rd_ptr + AW'(1);
        trace_rd_data <= mem[rd_ptr];
      end
      trace_count <= count_nx;
      trace_empty <= (count_nx == {(AW + 1){1'b0}});
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // Trace storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cpu_output;
  end

`ifdef CPU_SEQ_SIGNATURE_EN
  // Rolling signature: rotate left by one, fold in the current output
  always_ff @(posedge clk) begin
    if (!reset) begin
      signature <= {DATA_W{1'b0}};
    end else if (state == S_RST) begin
      signature <= {DATA_W{1'b0}};
    end else if (state == S_RUN) begin
      signature <= {signature[DATA_W-2:0], signature[DATA_W-1]} ^ cpu_output;
    end
  end
`else
  assign signature = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer against a cycle-level behavioural run model.
module tb_cpu_run_sequencer;
  localparam int DW  = 32;
  localparam int TD  = 16;
  localparam int RC  = 2;
  localparam int ST  = 8;
  localparam int MAX = 20;

  logic          clk, reset, start, trace_rd_en;
  logic [DW-1:0] cpu_output;
  logic          cpu_reset, running, done, timeout, overflow, trace_empty;
  logic [15:0]   cycle_count;
  logic [DW-1:0] trace_rd_data, signature;
  logic [4:0]    trace_count;

  int checks = 0;
  int errors = 0;

  // behavioural run model
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_last, m_rd, m_sig;
  int  m_cyc, m_run;
  bit  m_active, m_done, m_timeout, m_ovf;

  cpu_run_sequencer #(.MAX_CYCLES(MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_output(cpu_output),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .overflow(overflow), .cycle_count(cycle_count), .trace_rd_en(trace_rd_en),
    .trace_rd_data(trace_rd_data), .trace_empty(trace_empty),
    .trace_count(trace_count), .signature(signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start and count the cycles spent with the CPU held in reset before RUN.
  task automatic start_run(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (running) break;
      n++;
      tick();
    end
    m_q.delete();
    m_cyc = 0; m_run = 0; m_ovf = 1'b0; m_sig = '0;
    m_active = 1'b1; m_done = 1'b0; m_timeout = 1'b0;
  endtask

  // Apply one cycle of stimulus and advance the model by the rules of a run.
  task automatic run_cycle(input logic [DW-1:0] v, input bit do_pop);
    cpu_output  = v;
    trace_rd_en = do_pop;
    tick();
    trace_rd_en = 1'b0;
    if (do_pop && m_q.size() > 0) m_rd = m_q.pop_front();
    if (m_active) begin
      m_cyc++;
      if (m_cyc == 1 || v != m_last) begin
        m_run = 1;
        if (m_q.size() < TD) m_q.push_back(v);
        else m_ovf = 1'b1;
      end else if (m_run < ST) begin
        m_run++;
      end
      m_last = v;
`ifdef CPU_SEQ_SIGNATURE_EN
      m_sig = {m_sig[DW-2:0], m_sig[DW-1]} ^ v;
`else
      m_sig = '0;
`endif
      if (m_run == ST) begin
        m_done = 1'b1; m_timeout = 1'b0; m_active = 1'b0;
      end else if (m_cyc == MAX) begin
        m_done = 1'b1; m_timeout = 1'b1; m_active = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1;
    repeat (3) tick();
    checks += 5;
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (trace_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", trace_empty); end
    if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    if (trace_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", trace_rd_data); end
    start = 1'b0; reset = 1'b1;
    tick();
    checks += 2;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: running %b want 0", running); end
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_idle_cpu_reset: got %b want 1", cpu_reset); end
    m_rd = '0;
  endtask

  task automatic test_halt;
    int n;
    logic [DW-1:0] seq [4];
    seq[0] = 32'd0; seq[1] = 32'd5; seq[2] = 32'd5; seq[3] = 32'd9;
    start_run(n);
    checks++;
    if (n != RC) begin errors++; $display("FAIL halt_reset_cycles: got %0d want %0d", n, RC); end
    for (int i = 0; i < 40 && !m_done; i++) begin
      run_cycle((i < 4) ? seq[i] : 32'd9, 1'b0);
      checks += 2;
      if (cycle_count !== 16'(m_cyc)) begin errors++; $display("FAIL halt_count: got %0d want %0d", cycle_count, m_cyc); end
      if (done !== m_done) begin errors++; $display("FAIL halt_done: got %b want %b", done, m_done); end
    end
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL halt_final_done: got %b want 1", done); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL halt_timeout: got %b want 0", timeout); end
    if (trace_count !== 5'd3) begin errors++; $display("FAIL halt_trace_count: got %0d want 3", trace_count); end
    for (int i = 0; i < 40 && m_q.size() > 0; i++) begin
      run_cycle(32'd9, 1'b1);
      checks++;
      if (trace_rd_data !== m_rd) begin errors++; $display("FAIL halt_pop: got %0d want %0d", trace_rd_data, m_rd); end
    end
    run_cycle(32'd9, 1'b1);
    checks += 2;
    if (trace_rd_data !== 32'd9) begin errors++; $display("FAIL pop_empty_hold: got %0d want 9", trace_rd_data); end
    if (trace_empty !== 1'b1) begin errors++; $display("FAIL pop_empty_flag: got %b want 1", trace_empty); end
  endtask

  task automatic test_timeout;
    int n;
    start_run(n);
    for (int i = 0; i < 40 && !m_done; i++) begin
      run_cycle(m_last + 32'd1 + 32'($urandom_range(0, 100)), 1'b0);
      checks++;
      if (cycle_count !== 16'(m_cyc)) begin errors++; $display("FAIL to_count: got %0d want %0d", cycle_count, m_cyc); end
    end
    checks += 5;
    if (done !== 1'b1) begin errors++; $display("FAIL to_done: got %b want 1", done); end
    if (timeout !== 1'b1) begin errors++; $display("FAIL to_timeout: got %b want 1", timeout); end
    if (overflow !== m_ovf) begin errors++; $display("FAIL to_overflow: got %b want %b", overflow, m_ovf); end
    if (cycle_count !== 16'(MAX)) begin errors++; $display("FAIL to_final_count: got %0d want %0d", cycle_count, MAX); end
    if (trace_count !== 5'(m_q.size())) begin errors++; $display("FAIL to_trace_count: got %0d want %0d", trace_count, m_q.size()); end
  endtask

  task automatic test_restart;
    int n;
    start_run(n);
    checks += 5;
    if (n != RC) begin errors++; $display("FAIL rs_reset_cycles: got %0d want %0d", n, RC); end
    if (trace_empty !== 1'b1) begin errors++; $display("FAIL rs_empty: got %b want 1", trace_empty); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rs_overflow: got %b want 0", overflow); end
    if (cycle_count !== 16'd0) begin errors++; $display("FAIL rs_count: got %0d want 0", cycle_count); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL rs_timeout: got %b want 0", timeout); end
    for (int i = 0; i < 3; i++) run_cycle(32'(i + 100), 1'b0);
    reset = 1'b0;
    tick();
    checks += 4;
    if (running !== 1'b0) begin errors++; $display("FAIL abort_running: got %b want 0", running); end
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL abort_cpu_reset: got %b want 1", cpu_reset); end
    if (cycle_count !== 16'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", cycle_count); end
    if (trace_empty !== 1'b1) begin errors++; $display("FAIL abort_empty: got %b want 1", trace_empty); end
    reset = 1'b1;
    m_q.delete(); m_rd = '0; m_active = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    tick();
    checks += 2;
    if (done !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL abort_idle: done %b running %b want 0 0", done, running); end
    if (trace_rd_data !== m_rd) begin errors++; $display("FAIL abort_rd_data: got %h want %h", trace_rd_data, m_rd); end
  endtask

  task automatic test_fifo_boundary;
    int n;
    start_run(n);
    for (int i = 0; i < TD; i++) run_cycle(32'(i * 3 + 1), 1'b0);
    checks += 2;
    if (trace_count !== 5'd16) begin errors++; $display("FAIL fb_full_count: got %0d want 16", trace_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL fb_full_ovf: got %b want 0", overflow); end
    run_cycle(32'd999, 1'b1);
    checks += 3;
    if (trace_count !== 5'd16) begin errors++; $display("FAIL fb_pushpop_count: got %0d want 16", trace_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL fb_pushpop_ovf: got %b want 0", overflow); end
    if (trace_rd_data !== m_rd) begin errors++; $display("FAIL fb_pushpop_data: got %0d want %0d", trace_rd_data, m_rd); end
    for (int i = 0; i < 40 && !m_done; i++) run_cycle(32'd999, 1'b0);
    checks += 3;
    if (overflow !== m_ovf) begin errors++; $display("FAIL fb_end_ovf: got %b want %b", overflow, m_ovf); end
    if (timeout !== m_timeout) begin errors++; $display("FAIL fb_end_timeout: got %b want %b", timeout, m_timeout); end
    if (done !== 1'b1) begin errors++; $display("FAIL fb_end_done: got %b want 1", done); end
  endtask

  task automatic test_signature;
    int n;
    start_run(n);
    for (int i = 0; i < 40 && !m_done; i++) begin
      run_cycle((i == 0) ? 32'd1 : 32'd2, 1'b0);
      checks++;
      if (signature !== m_sig) begin errors++; $display("FAIL sig_cycle%0d: got %h want %h", i, signature, m_sig); end
      if (i == 1) begin
        checks++;
        if (signature !== 32'h0) begin errors++; $display("FAIL sig_two_cycles: got %h want 00000000", signature); end
      end
    end
    run_cycle(32'd77, 1'b0);
    checks++;
    if (signature !== m_sig) begin errors++; $display("FAIL sig_frozen: got %h want %h", signature, m_sig); end
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 6; r++) begin
      start_run(n);
      for (int i = 0; i < 60 && !(m_done && m_q.size() == 0); i++) begin
        run_cycle(32'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) || m_done);
        checks += 6;
        if (cycle_count !== 16'(m_cyc)) begin errors++; $display("FAIL rnd_count: got %0d want %0d", cycle_count, m_cyc); end
        if (trace_count !== 5'(m_q.size())) begin errors++; $display("FAIL rnd_trace_count: got %0d want %0d", trace_count, m_q.size()); end
        if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow: got %b want %b", overflow, m_ovf); end
        if (trace_rd_data !== m_rd) begin errors++; $display("FAIL rnd_rd_data: got %h want %h", trace_rd_data, m_rd); end
        if (done !== m_done || (m_done && timeout !== m_timeout)) begin
          errors++; $display("FAIL rnd_done: done %b timeout %b want %b %b", done, timeout, m_done, m_timeout);
        end
        if (signature !== m_sig) begin errors++; $display("FAIL rnd_sig: got %h want %h", signature, m_sig); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; trace_rd_en = 1'b0; cpu_output = '0;
    m_last = '0; m_rd = '0; m_sig = '0;
    m_cyc = 0; m_run = 0; m_active = 1'b0; m_done = 1'b0; m_timeout = 1'b0; m_ovf = 1'b0;
    test_reset();
    test_halt();
    test_timeout();
    test_restart();
    test_fifo_boundary();
    test_signature();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
